// File: rtl/mem_stage.sv
// Memory-access pipeline stage: loads/stores over a req/gnt/rvalid port,
// byte-lane steering, load extension and the MEM/WB pipeline register.
module mem_stage #(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          memRead,
  input  logic          memWrite,
  input  logic [2:0]    funct3,
  input  logic [1:0]    mem2regIn,
  input  logic          regWriteIn,
  input  logic [RW-1:0] rdIn,
  input  logic [N-1:0]  ALUresIn,
  input  logic [N-1:0]  storeData,
  input  logic [N-1:0]  NPCin,
  output logic          stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [N-1:0]  dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [N-1:0]  dmem_wdata,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [N-1:0]  dmem_rdata,
  output logic          wb_valid,
  output logic [1:0]    mem2reg,
  output logic          regWrite,
  output logic [RW-1:0] rd,
  output logic [N-1:0]  ALUres,
  output logic [N-1:0]  MEMread,
  output logic [N-1:0]  NPCout,
  output logic          misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic       mem_op;
  logic       legal;
  logic       bad;
  logic       sz_b;
  logic       sz_h;
  logic       sz_w;
  logic       load_done;
  logic [1:0] off;
  logic [3:0] be_raw;
  logic [N-1:0] rshift;
  logic [7:0]   lb;
  logic [15:0]  lh;
  logic [N-1:0] ext;

  assign off    = ALUresIn[1:0];
  assign mem_op = in_valid & (memRead | memWrite);
  assign sz_b   = (funct3[1:0] == 2'b00);
  assign sz_h   = (funct3[1:0] == 2'b01);
  assign sz_w   = (funct3[1:0] == 2'b10);

  // Legal size/sign encodings
  always_comb begin
    legal = 1'b0;
    unique case (funct3)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101: legal = 1'b1;
      default:        legal = 1'b0;
    endcase
  end

  assign bad = mem_op & (~legal
             | (sz_h & off[0])
             | (sz_w & (off != 2'b00)));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, request and stall generation
  always_comb begin
    state_nx  = state;
    dmem_req  = 1'b0;
    stall     = 1'b0;
    load_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op & ~bad) begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            if (memRead) begin
              state_nx = WAIT;
              stall    = 1'b1;
            end
          end else begin
            state_nx = REQ;
            stall    = 1'b1;
          end
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        stall    = 1'b1;
        if (dmem_gnt) begin
          if (memRead) begin
            state_nx = WAIT;
          end else begin
            state_nx = IDLE;
            stall    = 1'b0;
          end
        end
      end
      WAIT: begin
        stall = ~dmem_rvalid;
        if (dmem_rvalid) begin
          state_nx  = IDLE;
          load_done = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dmem_we   = memWrite & ~memRead;
  assign dmem_addr = {ALUresIn[N-1:2], 2'b00};

  // Byte enables and lane-replicated store data
  always_comb begin
    be_raw     = 4'b1111;
    dmem_wdata = storeData;
    if (sz_b) begin
      be_raw     = 4'b0001 << off;
      dmem_wdata = {4{storeData[7:0]}};
    end else if (sz_h) begin
      be_raw     = off[1] ? 4'b1100 : 4'b0011;
      dmem_wdata = {2{storeData[15:0]}};
    end
  end

  assign dmem_be = dmem_req ? be_raw : 4'b0000;

  assign rshift = dmem_rdata >> {off, 3'b000};
  assign lb     = rshift[7:0];
  assign lh     = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  // Load lane extraction with sign/zero extension
  always_comb begin
    ext = dmem_rdata;
    unique case (funct3)
      3'b000:  ext = {{(N-8){lb[7]}}, lb};
      3'b001:  ext = {{(N-16){lh[15]}}, lh};
      3'b100:  ext = {{(N-8){1'b0}}, lb};
      3'b101:  ext = {{(N-16){1'b0}}, lh};
      default: ext = dmem_rdata;
    endcase
  end

  // MEM/WB register: load when free, bubble while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      mem2reg    <= '0;
      regWrite   <= 1'b0;
      rd         <= '0;
      ALUres     <= '0;
      MEMread    <= '0;
      NPCout     <= '0;
      misaligned <= 1'b0;
    end else if (stall) begin
      wb_valid <= 1'b0;
      regWrite <= 1'b0;
    end else begin
      wb_valid   <= in_valid;
      mem2reg    <= mem2regIn;
      regWrite   <= regWriteIn & in_valid & ~bad;
      rd         <= rdIn;
      ALUres     <= ALUresIn;
      MEMread    <= load_done ? ext : '0;
      NPCout     <= NPCin;
      misaligned <= bad;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed stimulus, write-back scoreboard
// and a decoupled monitor.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [1:0]  mem2regIn;
  logic        regWriteIn;
  logic [4:0]  rdIn;
  logic [31:0] ALUresIn;
  logic [31:0] storeData;
  logic [31:0] NPCin;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [1:0]  mem2reg;
  logic        regWrite;
  logic [4:0]  rd;
  logic [31:0] ALUres;
  logic [31:0] MEMread;
  logic [31:0] NPCout;
  logic        misaligned;

  mem_stage #(.N(32), .RW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .mem2regIn(mem2regIn), .regWriteIn(regWriteIn),
    .rdIn(rdIn), .ALUresIn(ALUresIn), .storeData(storeData),
    .NPCin(NPCin), .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .mem2reg(mem2reg), .regWrite(regWrite),
    .rd(rd), .ALUres(ALUres), .MEMread(MEMread), .NPCout(NPCout),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mr;
    logic [31:0] npc;
    logic [4:0]  rd;
    logic [1:0]  m2r;
    logic        rw;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic push(logic [31:0] alu, logic [31:0] mr,
                      logic [31:0] npc, logic [4:0] r,
                      logic [1:0] m2r, logic rw, logic mis);
    exp_t e;
    e.alu = alu; e.mr = mr; e.npc = npc; e.rd = r;
    e.m2r = m2r; e.rw = rw; e.mis = mis;
    sb.push_back(e);
  endtask

  // Monitor: every presented write-back entry must match the queue head
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_wb: got alu %h expected no entry",
                 ALUres);
      end else begin
        me = sb.pop_front();
        chk("wb_alu", ALUres, me.alu);
        chk("wb_memread", MEMread, me.mr);
        chk("wb_npc", NPCout, me.npc);
        chk("wb_rd", {27'd0, rd}, {27'd0, me.rd});
        chk("wb_m2r", {30'd0, mem2reg}, {30'd0, me.m2r});
        chk("wb_regwrite", {31'd0, regWrite}, {31'd0, me.rw});
        chk("wb_misaligned", {31'd0, misaligned}, {31'd0, me.mis});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    regWriteIn = 1'b0;
  endtask

  task automatic drive(logic rd_, logic wr_, logic [2:0] f3,
                       logic rwi, logic [4:0] r, logic [1:0] m2r,
                       logic [31:0] alu, logic [31:0] sd,
                       logic [31:0] npc);
    in_valid = 1'b1; memRead = rd_; memWrite = wr_;
    funct3 = f3; regWriteIn = rwi; rdIn = r; mem2regIn = m2r;
    ALUresIn = alu; storeData = sd; NPCin = npc;
  endtask

  task automatic load_seq(logic [2:0] f3, logic [31:0] rdata,
                          logic [31:0] expv);
    drive(1, 0, f3, 1, 5'd7, 2'b01, 32'h102, 32'h0, 32'h50);
    dmem_gnt = 1'b1;
    push(32'h102, expv, 32'h50, 5'd7, 2'b01, 1'b1, 1'b0);
    #2;
    chk("lb_c0_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_c0_stall", {31'd0, stall}, 32'd1);
    chk("lb_c0_be", {28'd0, dmem_be}, 32'h4);
    step();
    dmem_gnt = 1'b0;
    #2;
    chk("lb_c1_stall", {31'd0, stall}, 32'd1);
    chk("lb_c1_req", {31'd0, dmem_req}, 32'd0);
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #2;
    chk("lb_c2_stall", {31'd0, stall}, 32'd0);
    step();
    dmem_rvalid = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    funct3 = 3'b000; mem2regIn = 2'b00; rdIn = 5'd0;
    ALUresIn = 32'h0; storeData = 32'h0; NPCin = 32'h0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;

    step();
    #2;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_memread", MEMread, 32'd0);
    rst = 1'b0;
    step();

    // Load granted, reset pulse while waiting, late rvalid ignored
    drive(1, 0, 3'b010, 1, 5'd4, 2'b01, 32'h10, 32'h0, 32'h20);
    dmem_gnt = 1'b1;
    #2;
    chk("rw_req", {31'd0, dmem_req}, 32'd1);
    chk("rw_stall", {31'd0, stall}, 32'd1);
    step();
    dmem_gnt = 1'b0;
    idle();
    rst = 1'b1;
    #1;
    chk("rw_rst_stall", {31'd0, stall}, 32'd0);
    chk("rw_rst_wbv", {31'd0, wb_valid}, 32'd0);
    rst = 1'b0;
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEADBEEF;
    #2;
    chk("rw_late_stall", {31'd0, stall}, 32'd0);
    chk("rw_late_req", {31'd0, dmem_req}, 32'd0);
    step();
    dmem_rvalid = 1'b0;
    #2;
    chk("rw_late_wbv", {31'd0, wb_valid}, 32'd0);
    step();

    // ALU op
    drive(0, 0, 3'b000, 1, 5'd5, 2'b00, 32'h1234, 32'h0, 32'h44);
    push(32'h1234, 32'h0, 32'h44, 5'd5, 2'b00, 1'b1, 1'b0);
    #2;
    chk("alu_req", {31'd0, dmem_req}, 32'd0);
    chk("alu_stall", {31'd0, stall}, 32'd0);
    step();
    idle();

    // SB at 0x103
    drive(0, 1, 3'b000, 0, 5'd0, 2'b00, 32'h103, 32'hAB, 32'h48);
    dmem_gnt = 1'b1;
    push(32'h103, 32'h0, 32'h48, 5'd0, 2'b00, 1'b0, 1'b0);
    #2;
    chk("sb_req", {31'd0, dmem_req}, 32'd1);
    chk("sb_we", {31'd0, dmem_we}, 32'd1);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_be", {28'd0, dmem_be}, 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hABABABAB);
    chk("sb_stall", {31'd0, stall}, 32'd0);
    step();

    // SH at 0x102
    drive(0, 1, 3'b001, 0, 5'd0, 2'b00, 32'h102, 32'h1234CDEF, 32'h4C);
    push(32'h102, 32'h0, 32'h4C, 5'd0, 2'b00, 1'b0, 1'b0);
    #2;
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hCDEFCDEF);
    step();

    // SW at 0x200, grant one cycle late
    drive(0, 1, 3'b010, 0, 5'd0, 2'b00, 32'h200, 32'h11223344, 32'h60);
    dmem_gnt = 1'b0;
    push(32'h200, 32'h0, 32'h60, 5'd0, 2'b00, 1'b0, 1'b0);
    #2;
    chk("sw_c0_stall", {31'd0, stall}, 32'd1);
    chk("sw_c0_be", {28'd0, dmem_be}, 32'hF);
    step();
    dmem_gnt = 1'b1;
    #2;
    chk("sw_c1_req", {31'd0, dmem_req}, 32'd1);
    chk("sw_c1_stall", {31'd0, stall}, 32'd0);
    chk("sw_c1_wdata", dmem_wdata, 32'h11223344);
    step();
    dmem_gnt = 1'b0;
    idle();
    step();

    // LB / LBU at 0x102
    load_seq(3'b000, 32'h00800000, 32'hFFFFFF80);
    load_seq(3'b100, 32'h00800000, 32'h00000080);

    // LH at 0x106 with grant withheld three cycles
    drive(1, 0, 3'b001, 1, 5'd9, 2'b01, 32'h106, 32'h0, 32'h58);
    dmem_gnt = 1'b0;
    push(32'h106, 32'hFFFFBEEF, 32'h58, 5'd9, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("lh_wait_req", {31'd0, dmem_req}, 32'd1);
      chk("lh_wait_stall", {31'd0, stall}, 32'd1);
      chk("lh_wait_be", {28'd0, dmem_be}, 32'hC);
      step();
    end
    dmem_gnt = 1'b1;
    #2;
    chk("lh_gnt_req", {31'd0, dmem_req}, 32'd1);
    chk("lh_gnt_stall", {31'd0, stall}, 32'd1);
    step();
    dmem_gnt = 1'b0;
    #2;
    chk("lh_rv0_req", {31'd0, dmem_req}, 32'd0);
    chk("lh_rv0_stall", {31'd0, stall}, 32'd1);
    step();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hBEEF1234;
    #2;
    chk("lh_rv1_stall", {31'd0, stall}, 32'd0);
    step();
    dmem_rvalid = 1'b0;
    idle();

    // Misaligned LW at 0x101
    drive(1, 0, 3'b010, 1, 5'd3, 2'b01, 32'h101, 32'h0, 32'h5C);
    dmem_gnt = 1'b1;
    push(32'h101, 32'h0, 32'h5C, 5'd3, 2'b01, 1'b0, 1'b1);
    #2;
    chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lw_mis_stall", {31'd0, stall}, 32'd0);
    chk("lw_mis_be", {28'd0, dmem_be}, 32'h0);
    step();
    dmem_gnt = 1'b0;
    idle();

    repeat (3) step();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
